// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings for the LED sequencer.
package led_seq_pkg;
   typedef enum logic [1:0] {
      SEQ_IDLE = 2'b00,
      SEQ_RUN  = 2'b01,
      SEQ_DONE = 2'b10
   } seq_state_t;
   typedef enum logic [1:0] {
      WALK_UP   = 2'b00,
      WALK_DOWN = 2'b01,
      BOUNCE    = 2'b10,
      FILL      = 2'b11
   } mode_t;
   localparam logic [1:0] DEFAULT_TRIGGER = 2'b11;
endpackage

// File: rtl/led_dwell_timer.sv
// led_dwell_timer: counts 0..DWELL_CYCLES-1 while enabled, ticks on the terminal count.
// tick_ahead flags that the following cycle will be a terminal count.
module led_dwell_timer #(
   parameter int DWELL_CYCLES = 50000000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clear,
   input  logic enable,
   output logic tick,
   output logic tick_ahead
);
   localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] AHEAD = CNT_W'(DWELL_CYCLES > 1 ? DWELL_CYCLES - 2 : 0);
   logic [CNT_W-1:0] cnt;
   assign tick       = enable && cnt == LAST;
   assign tick_ahead = DWELL_CYCLES == 1 || (enable && cnt == AHEAD);
   always_ff @(posedge CLK or posedge RESET)
      if (RESET)
         cnt <= '0;
      else if (clear || tick)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + 1'b1;
endmodule

// File: rtl/led_sequencer_sm.sv
// led_sequencer_sm: steps an LED pattern while slaved to the master state bus.
// Define LED_SEQ_ABORT_EN to abandon a run when the master leaves the trigger state.
module led_sequencer_sm
   import led_seq_pkg::*;
#(
   parameter int         NUM_LEDS      = 8,
   parameter int         DWELL_CYCLES  = 50000000,
   parameter logic [1:0] TRIGGER_STATE = DEFAULT_TRIGGER
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [1:0]                  MASTER_STATE,
   input  logic [1:0]                  MODE,
   input  logic [3:0]                  REPEAT,
   output logic [NUM_LEDS-1:0]         LED_OUT,
   output logic [1:0]                  SEQ_STATE_OUT,
   output logic [$clog2(NUM_LEDS)-1:0] STEP_OUT,
   output logic                        PASS_DONE
);
   localparam int POS_W = $clog2(NUM_LEDS);
   localparam logic [POS_W-1:0]    TOP  = POS_W'(NUM_LEDS - 1);
   localparam logic [NUM_LEDS-1:0] ONE  = NUM_LEDS'(1);
   localparam logic [NUM_LEDS-1:0] ONES = {NUM_LEDS{1'b1}};
   seq_state_t state, nxt_state;
   mode_t mode_q, nxt_mode;
   logic [3:0] rep_q, nxt_rep, passes, nxt_pass;
   logic [POS_W-1:0] pos, nxt_pos, adv_pos;
   logic dn, nxt_dn, adv_dn, trig, tick, tick_ahead;
   function automatic logic [NUM_LEDS-1:0] pattern(mode_t m, logic [POS_W-1:0] p);
      return m == FILL ? ONES >> (NUM_LEDS - 1 - int'(p)) : ONE << p;
   endfunction
   // Bounce with two LEDs has no return leg, so its pass ends at the top.
   function automatic logic is_last(mode_t m, logic [POS_W-1:0] p, logic d);
      return m == WALK_DOWN ? p == '0 : ((m == BOUNCE && NUM_LEDS > 2) ? (d && p == POS_W'(1)) : p == TOP);
   endfunction
   function automatic logic [POS_W-1:0] start_pos(mode_t m);
      return m == WALK_DOWN ? TOP : '0;
   endfunction
   assign trig    = MASTER_STATE == TRIGGER_STATE;
   assign adv_pos = (mode_q == WALK_DOWN || (mode_q == BOUNCE && (dn || pos == TOP))) ? pos - 1'b1 : pos + 1'b1;
   assign adv_dn  = mode_q == BOUNCE && (dn || pos == TOP);
   led_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
      .CLK       (CLK),
      .RESET     (RESET),
      .clear     (state != SEQ_RUN),
      .enable    (state == SEQ_RUN),
      .tick      (tick),
      .tick_ahead(tick_ahead)
   );
   always_comb begin
      nxt_state = state;
      nxt_mode  = mode_q;
      nxt_rep   = rep_q;
      nxt_pass  = passes;
      nxt_pos   = pos;
      nxt_dn    = dn;
      case (state)
         SEQ_IDLE:
            if (trig) begin
               nxt_state = SEQ_RUN;
               nxt_mode  = mode_t'(MODE);
               nxt_rep   = REPEAT;
               nxt_pass  = '0;
               nxt_pos   = start_pos(mode_t'(MODE));
               nxt_dn    = 1'b0;
            end
         SEQ_RUN:
`ifdef LED_SEQ_ABORT_EN
            if (!trig) begin
               nxt_state = SEQ_IDLE;
               nxt_pos   = '0;
            end else
`endif
            if (tick) begin
               if (!is_last(mode_q, pos, dn)) begin
                  nxt_pos = adv_pos;
                  nxt_dn  = adv_dn;
               end else if (passes == rep_q) begin
                  nxt_state = SEQ_DONE;
                  nxt_pos   = '0;
               end else begin
                  nxt_pos  = start_pos(mode_q);
                  nxt_dn   = 1'b0;
                  nxt_pass = passes + 1'b1;
               end
            end
         SEQ_DONE:
            if (!trig) nxt_state = SEQ_IDLE;
         default: begin
            nxt_state = SEQ_IDLE;
            nxt_pos   = '0;
         end
      endcase
   end
   // Outputs are computed from next-state values so they line up with the state they describe.
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state     <= SEQ_IDLE;
         mode_q    <= WALK_UP;
         rep_q     <= '0;
         passes    <= '0;
         pos       <= '0;
         dn        <= 1'b0;
         LED_OUT   <= '0;
         PASS_DONE <= 1'b0;
      end else begin
         state     <= nxt_state;
         mode_q    <= nxt_mode;
         rep_q     <= nxt_rep;
         passes    <= nxt_pass;
         pos       <= nxt_pos;
         dn        <= nxt_dn;
         LED_OUT   <= nxt_state == SEQ_RUN ? pattern(nxt_mode, nxt_pos) : '0;
         PASS_DONE <= nxt_state == SEQ_RUN && is_last(nxt_mode, nxt_pos, nxt_dn) && tick_ahead;
      end
   assign SEQ_STATE_OUT = state;
   assign STEP_OUT      = pos;
endmodule

// File: tb/tb_led_sequencer_sm.sv
// tb_led_sequencer_sm: directed-vector bench for led_sequencer_sm with 4 LEDs and a 3-cycle dwell.
module tb_led_sequencer_sm;
   logic       CLK = 1'b0;
   logic       RESET;
   logic [1:0] MASTER_STATE, MODE, SEQ_STATE_OUT, STEP_OUT;
   logic [3:0] REPEAT, LED_OUT;
   logic       PASS_DONE;
   int vectors = 0, miscompares = 0;
   logic [3:0] seq [6];
   logic [1:0] stp [6];
   led_sequencer_sm #(.NUM_LEDS(4), .DWELL_CYCLES(3), .TRIGGER_STATE(2'b11)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .MASTER_STATE (MASTER_STATE),
      .MODE         (MODE),
      .REPEAT       (REPEAT),
      .LED_OUT      (LED_OUT),
      .SEQ_STATE_OUT(SEQ_STATE_OUT),
      .STEP_OUT     (STEP_OUT),
      .PASS_DONE    (PASS_DONE)
   );
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic start(input logic [1:0] m, input logic [3:0] r);
      @(negedge CLK);
      MASTER_STATE = 2'b11;
      MODE = m;
      REPEAT = r;
   endtask
   // Walks the table in seq/stp for the given passes; MODE/REPEAT are scrambled after the run starts.
   task automatic expect_run(input string tag, input int n, input int passes);
      for (int p = 0; p < passes; p++)
         for (int s = 0; s < n; s++)
            for (int d = 0; d < 3; d++) begin
               @(negedge CLK);
               if (p == 0 && s == 0 && d == 0) begin
                  MODE = ~MODE;
                  REPEAT = ~REPEAT;
               end
               check({tag, " led"}, 32'(LED_OUT), 32'(seq[s]));
               check({tag, " pass_done"}, 32'(PASS_DONE), 32'(s == n - 1 && d == 2));
               if (d == 0) begin
                  check({tag, " step"}, 32'(STEP_OUT), 32'(stp[s]));
                  check({tag, " state"}, 32'(SEQ_STATE_OUT), 32'h1);
               end
            end
      @(negedge CLK);
      check({tag, " done state"}, 32'(SEQ_STATE_OUT), 32'h2);
      check({tag, " done led"}, 32'(LED_OUT), 32'h0);
      check({tag, " done step"}, 32'(STEP_OUT), 32'h0);
      check({tag, " done pass_done"}, 32'(PASS_DONE), 32'h0);
   endtask
   task automatic leave_done(input string tag);
      MASTER_STATE = 2'b00;
      @(negedge CLK);
      check({tag, " idle"}, 32'(SEQ_STATE_OUT), 32'h0);
   endtask
   initial begin
      RESET = 1'b1;
      MASTER_STATE = 2'b00;
      MODE = 2'b00;
      REPEAT = 4'h0;
      repeat (2) @(negedge CLK);
      check("reset state", 32'(SEQ_STATE_OUT), 32'h0);
      check("reset led", 32'(LED_OUT), 32'h0);
      check("reset step", 32'(STEP_OUT), 32'h0);
      check("reset pass_done", 32'(PASS_DONE), 32'h0);
      RESET = 1'b0;
      @(negedge CLK);
      check("idle no trigger", 32'(SEQ_STATE_OUT), 32'h0);
      seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
      stp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
      start(2'b00, 4'd0);
      expect_run("walkup", 4, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check("done hold", 32'(SEQ_STATE_OUT), 32'h2);
      end
      leave_done("walkup");
      seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
      stp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
      start(2'b10, 4'd1);
      expect_run("bounce", 6, 2);
      leave_done("bounce");
      seq = '{4'h1, 4'h3, 4'h7, 4'hf, 4'h0, 4'h0};
      stp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
      start(2'b11, 4'd2);
      expect_run("fill", 4, 3);
      leave_done("fill");
      seq = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0};
      stp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
      start(2'b01, 4'd0);
      expect_run("walkdown", 4, 1);
      leave_done("walkdown");
      start(2'b00, 4'd0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         check("leave led", 32'(LED_OUT), c < 4 ? 32'h1 : 32'h2);
      end
      MASTER_STATE = 2'b01;
`ifdef LED_SEQ_ABORT_EN
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         check("abort state", 32'(SEQ_STATE_OUT), 32'h0);
         check("abort led", 32'(LED_OUT), 32'h0);
         check("abort pass_done", 32'(PASS_DONE), 32'h0);
      end
`else
      for (int c = 5; c <= 12; c++) begin
         @(negedge CLK);
         check("leave led", 32'(LED_OUT), 32'h1 << ((c - 1) / 3));
         check("leave pass_done", 32'(PASS_DONE), 32'(c == 12));
      end
      @(negedge CLK);
      check("leave done", 32'(SEQ_STATE_OUT), 32'h2);
      @(negedge CLK);
      check("leave idle", 32'(SEQ_STATE_OUT), 32'h0);
`endif
      MASTER_STATE = 2'b00;
      @(negedge CLK);
      start(2'b11, 4'd0);
      repeat (5) @(negedge CLK);
      check("pre-reset led", 32'(LED_OUT), 32'h3);
      #2 RESET = 1'b1;
      #1;
      check("async reset led", 32'(LED_OUT), 32'h0);
      check("async reset state", 32'(SEQ_STATE_OUT), 32'h0);
      check("async reset step", 32'(STEP_OUT), 32'h0);
      @(negedge CLK);
      RESET = 1'b0;
      MASTER_STATE = 2'b00;
      @(negedge CLK);
      check("post reset idle", 32'(SEQ_STATE_OUT), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
